// File: rtl/adc_spi_pkg.sv
// Shared constants and FSM encoding for the ADC configuration SPI responder.
package adc_spi_pkg;

  localparam int unsigned FRAME_BITS = 24;
  localparam int unsigned ADDR_W     = 8;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned WR_BIT     = 7;

  localparam logic [6:0] SW_RST_ADDR    = 7'h04;
  localparam logic [6:0] FRAME_CNT_ADDR = 7'h7F;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StRData,
    StWData,
    StCommit,
    StDone
  } state_e;

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchronizer for an SPI pin, with single-cycle rise/fall pulses.
module spi_pin_sync (
  input  logic clk,
  input  logic sys_rst_n,
  input  logic pin_i,
  output logic rise_o,
  output logic fall_o
);

  // [1:0] synchronizer, [2] previous synchronized value. Resetting to 0 means a
  // CSB already low at reset release produces no fall, so that frame is ignored.
  logic [2:0] sync_q;

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= {sync_q[1:0], pin_i};
    end
  end

  assign rise_o = sync_q[1] & ~sync_q[2];
  assign fall_o = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/adc_spi_slave_regs.sv
// SPI mode-0 responder for 24-bit ADC config frames backed by a register bank.
// Optional frame counter at 0x7F: define ADC_SPI_SLAVE_FRAME_CNT_EN.
module adc_spi_slave_regs
  import adc_spi_pkg::*;
#(
  parameter int unsigned NUM_REGS = 16,
  parameter logic [15:0] RST_VAL  = 16'h0000
) (
  input  logic        clk,
  input  logic        sys_rst_n,
  input  logic        spi_sclk_i,
  input  logic        spi_csb_i,
  input  logic        spi_mosi_i,
  output logic        spi_miso_o,
  output logic        spi_miso_oe,
  output logic        reg_wr_stb,
  output logic [6:0]  reg_wr_addr,
  output logic [15:0] reg_wr_data,
  output logic        sw_rst_pulse,
  output logic        frame_err,
  input  logic [6:0]  dbg_addr,
  output logic [15:0] dbg_data
);

  localparam int unsigned IdxW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic sclk_rise, sclk_fall, csb_rise, csb_fall;
  logic [1:0] mosi_q;

  state_e              state_q, state_d;
  logic [4:0]          bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   shift_in_q, shift_in_d, shift_out_q, shift_out_d;
  logic [6:0]          addr_q, addr_d;
  logic                load_q, load_d, miso_q, miso_d;
  logic                wr_en, sw_rst;
  logic [ADDR_W-1:0]   addr_byte;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];

`ifdef ADC_SPI_SLAVE_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;
  logic        frame_done;
`endif

  spi_pin_sync u_sclk_sync (
    .clk      (clk),
    .sys_rst_n(sys_rst_n),
    .pin_i    (spi_sclk_i),
    .rise_o   (sclk_rise),
    .fall_o   (sclk_fall)
  );

  spi_pin_sync u_csb_sync (
    .clk      (clk),
    .sys_rst_n(sys_rst_n),
    .pin_i    (spi_csb_i),
    .rise_o   (csb_rise),
    .fall_o   (csb_fall)
  );

  function automatic logic [DATA_W-1:0] reg_read(input logic [6:0] a);
    reg_read = '0;
    if (32'(a) < NUM_REGS) begin
      reg_read = regs_q[a[IdxW-1:0]];
`ifdef ADC_SPI_SLAVE_FRAME_CNT_EN
    end else if (a == FRAME_CNT_ADDR) begin
      reg_read = frame_cnt_q;
`endif
    end
  endfunction

  assign addr_byte = {shift_in_q[ADDR_W-2:0], mosi_q[1]};

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_in_d  = shift_in_q;
    shift_out_d = shift_out_q;
    addr_d      = addr_q;
    load_d      = 1'b0;
    miso_d      = miso_q;
    frame_err   = 1'b0;
    wr_en       = 1'b0;
    sw_rst      = 1'b0;
    unique case (state_q)
      StIdle: begin
        miso_d = 1'b0;
        if (csb_fall) begin
          state_d   = StAddr;
          bit_cnt_d = '0;
        end
      end
      StAddr, StRData, StWData: begin
        // CSB rise wins over a coincident SCLK rise, including the 24th.
        if (csb_rise) begin
          state_d   = StIdle;
          frame_err = (bit_cnt_q != '0);
        end else begin
          if (sclk_rise) begin
            shift_in_d = {shift_in_q[DATA_W-2:0], mosi_q[1]};
            bit_cnt_d  = bit_cnt_q + 5'd1;
            if (state_q == StAddr && bit_cnt_q == 5'(ADDR_W - 1)) begin
              addr_d  = addr_byte[6:0];
              state_d = addr_byte[WR_BIT] ? StWData : StRData;
              load_d  = ~addr_byte[WR_BIT];
            end else if (bit_cnt_q == 5'(FRAME_BITS - 1)) begin
              state_d = (state_q == StWData) ? StCommit : StDone;
            end
          end
          if (state_q == StRData) begin
            if (load_q) begin
              shift_out_d = reg_read(addr_q);
            end else if (sclk_fall) begin
              miso_d      = shift_out_q[DATA_W-1];
              shift_out_d = {shift_out_q[DATA_W-2:0], 1'b0};
            end
          end
        end
      end
      StCommit: begin
        state_d = csb_rise ? StIdle : StDone;
        if (addr_q == SW_RST_ADDR && shift_in_q[0]) begin
          sw_rst = 1'b1;
        end else if (32'(addr_q) < NUM_REGS) begin
          wr_en = 1'b1;
        end
      end
      StDone: begin
        if (csb_rise) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shift_in_q  <= '0;
      shift_out_q <= '0;
      addr_q      <= '0;
      load_q      <= 1'b0;
      miso_q      <= 1'b0;
      mosi_q      <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_in_q  <= shift_in_d;
      shift_out_q <= shift_out_d;
      addr_q      <= addr_d;
      load_q      <= load_d;
      miso_q      <= miso_d;
      mosi_q      <= {mosi_q[0], spi_mosi_i};
    end
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= RST_VAL;
    end else if (sw_rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= RST_VAL;
    end else if (wr_en) begin
      regs_q[addr_q[IdxW-1:0]] <= shift_in_q;
    end
  end

`ifdef ADC_SPI_SLAVE_FRAME_CNT_EN
  // Every complete frame counts: reads at the 24th rise, writes in commit.
  assign frame_done = (state_q == StCommit) ||
                      (state_q == StRData && sclk_rise && !csb_rise &&
                       bit_cnt_q == 5'(FRAME_BITS - 1));

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      frame_cnt_q <= '0;
    end else if (sw_rst) begin
      frame_cnt_q <= '0;
    end else if (frame_done) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end
`endif

  assign spi_miso_oe  = (state_q == StRData) && !csb_rise;
  assign spi_miso_o   = spi_miso_oe & miso_q;
  assign reg_wr_stb   = wr_en;
  assign reg_wr_addr  = wr_en ? addr_q : '0;
  assign reg_wr_data  = wr_en ? shift_in_q : '0;
  assign sw_rst_pulse = sw_rst;
  assign dbg_data     = reg_read(dbg_addr);

endmodule

// File: tb/tb_adc_spi_slave_regs.sv
// Randomized self-checking bench for adc_spi_slave_regs against a frame-level model.
`timescale 1ns/1ps
module tb_adc_spi_slave_regs;

  localparam int NumRegs = 16;
  localparam int H       = 5;  // SCLK half period in clk cycles

  logic        clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        sclk = 1'b0, csb = 1'b1, mosi = 1'b0;
  logic        miso, miso_oe, wr_stb, sw_rst, ferr;
  logic [6:0]  wr_addr, dbg_addr = '0;
  logic [15:0] wr_data, dbg_data;

  always #5 clk = ~clk;

  adc_spi_slave_regs #(.NUM_REGS(NumRegs), .RST_VAL(16'h0000)) dut (
    .clk         (clk),
    .sys_rst_n   (sys_rst_n),
    .spi_sclk_i  (sclk),
    .spi_csb_i   (csb),
    .spi_mosi_i  (mosi),
    .spi_miso_o  (miso),
    .spi_miso_oe (miso_oe),
    .reg_wr_stb  (wr_stb),
    .reg_wr_addr (wr_addr),
    .reg_wr_data (wr_data),
    .sw_rst_pulse(sw_rst),
    .frame_err   (ferr),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output event monitor
  int stb_cnt = 0, sw_cnt = 0, fe_cnt = 0, viol_cnt = 0, stb_cyc = 0;
  logic [6:0]  last_addr = '0;
  logic [15:0] last_data = '0;
  always @(negedge clk) begin
    if (sys_rst_n) begin
      if (wr_stb) begin
        stb_cnt   <= stb_cnt + 1;
        last_addr <= wr_addr;
        last_data <= wr_data;
        stb_cyc   <= cyc;
      end
      if (sw_rst) sw_cnt <= sw_cnt + 1;
      if (ferr) fe_cnt <= fe_cnt + 1;
      if (!miso_oe && miso !== 1'b0) viol_cnt <= viol_cnt + 1;
    end
  end

  // Frame-level reference model
  logic [15:0] m_regs [NumRegs];
  logic [15:0] m_cnt = '0;

  function automatic logic [15:0] m_read(input logic [6:0] a);
    if (int'(a) < NumRegs) return m_regs[a[3:0]];
`ifdef ADC_SPI_SLAVE_FRAME_CNT_EN
    if (a == 7'h7F) return m_cnt;
`endif
    return 16'h0000;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NumRegs; i++) m_regs[i] = 16'h0000;
    m_cnt = '0;
  endtask

  // Results of the last frame: observed (r_d*) and expected (r_e*)
  int r_dstb, r_estb, r_dsw, r_esw, r_dfe, r_efe, r_lat, oe_err, rise_cyc;
  logic [15:0] rd_cap, r_erd;
  bit r_is_rd;

  task automatic csb_low();
    @(negedge clk) csb = 1'b0;
    repeat (H) @(negedge clk);
  endtask

  task automatic csb_high();
    repeat (H) @(negedge clk);
    csb = 1'b1;
    repeat (2 * H) @(negedge clk);
  endtask

  task automatic shift_bits(input logic [23:0] w, input int first, input int last, input bit is_rd);
    logic [23:0] sh;
    sh = w << first;
    for (int i = first; i < last; i++) begin
      mosi = sh[23];
      sh   = sh << 1;
      repeat (H) @(negedge clk);
      if (i >= 8 && i < 24) rd_cap[23 - i] = miso;
      if (miso_oe !== (is_rd && i >= 8 && i < 24)) oe_err++;
      sclk = 1'b1;
      if (i == 23) rise_cyc = cyc;
      repeat (H) @(negedge clk);
      sclk = 1'b0;
    end
    mosi = 1'b0;
  endtask

  task automatic do_frame(input logic [7:0] a8, input logic [15:0] d, input int nbits);
    int s0, w0, f0;
    logic [6:0] a;
    a = a8[6:0];
    r_is_rd = !a8[7];
    r_erd   = m_read(a);
    s0 = stb_cnt; w0 = sw_cnt; f0 = fe_cnt;
    oe_err = 0; rd_cap = '0;
    csb_low();
    shift_bits({a8, d}, 0, nbits, r_is_rd);
    csb_high();
    r_dstb = stb_cnt - s0; r_dsw = sw_cnt - w0; r_dfe = fe_cnt - f0;
    r_lat  = stb_cyc - rise_cyc;
    r_estb = 0; r_esw = 0; r_efe = 0;
    if (nbits >= 24) begin
      if (!r_is_rd && a == 7'h04 && d[0]) begin
        m_reset();
        r_esw = 1;
      end else begin
        m_cnt = m_cnt + 16'd1;
        if (!r_is_rd && int'(a) < NumRegs) begin
          m_regs[a[3:0]] = d;
          r_estb = 1;
        end
      end
    end else if (nbits > 0) begin
      r_efe = 1;
    end
  endtask

  task automatic test_reset();
    for (int a = 0; a < NumRegs; a++) begin
      dbg_addr = 7'(a); #1;
      n_tests++;
      if (dbg_data !== 16'h0000) begin
        n_fail++; $display("FAIL reset_reg[%0d] got %h want 0000", a, dbg_data);
      end
    end
    n_tests++;
    if ({miso, miso_oe, wr_stb, sw_rst, ferr} !== 5'b0) begin
      n_fail++; $display("FAIL reset_outputs got %b want 00000", {miso, miso_oe, wr_stb, sw_rst, ferr});
    end
  endtask

  task automatic test_write_read();
    do_frame(8'h81, 16'h1008, 24);
    n_tests++;
    if (r_dstb !== 1 || last_addr !== 7'h01 || last_data !== 16'h1008) begin
      n_fail++; $display("FAIL write_strobe got n=%0d a=%h d=%h want n=1 a=01 d=1008", r_dstb, last_addr, last_data);
    end
    n_tests++;
    if (r_lat !== 3) begin
      n_fail++; $display("FAIL write_latency got %0d want 3 clk after 24th rise drive", r_lat);
    end
    dbg_addr = 7'h01; #1;
    n_tests++;
    if (dbg_data !== 16'h1008) begin
      n_fail++; $display("FAIL write_dbg got %h want 1008", dbg_data);
    end
    do_frame(8'h01, 16'h0000, 24);
    n_tests++;
    if (rd_cap !== 16'h1008 || oe_err != 0) begin
      n_fail++; $display("FAIL read_miso got %h oe_err=%0d want 1008 oe_err=0", rd_cap, oe_err);
    end
  endtask

  task automatic test_soft_reset();
    do_frame(8'h82, 16'hABCD, 24);
    do_frame(8'h84, 16'h0001, 24);
    n_tests++;
    if (r_dsw !== 1 || r_dstb !== 0) begin
      n_fail++; $display("FAIL soft_reset got sw=%0d stb=%0d want sw=1 stb=0", r_dsw, r_dstb);
    end
    for (int a = 2; a <= 4; a += 2) begin
      dbg_addr = 7'(a); #1;
      n_tests++;
      if (dbg_data !== 16'h0000) begin
        n_fail++; $display("FAIL soft_reset_reg[%0d] got %h want 0000", a, dbg_data);
      end
    end
  endtask

  task automatic test_abort();
    do_frame(8'h83, 16'h5A5A, 24);
    do_frame(8'h83, 16'hFFFF, 12);
    n_tests++;
    if (r_dfe !== 1 || r_dstb !== 0) begin
      n_fail++; $display("FAIL abort_write got fe=%0d stb=%0d want fe=1 stb=0", r_dfe, r_dstb);
    end
    dbg_addr = 7'h03; #1;
    n_tests++;
    if (dbg_data !== 16'h5A5A) begin
      n_fail++; $display("FAIL abort_reg3 got %h want 5a5a", dbg_data);
    end
    do_frame(8'h03, 16'h0000, 16);
    n_tests++;
    if (r_dfe !== 1) begin
      n_fail++; $display("FAIL abort_read got fe=%0d want 1", r_dfe);
    end
    do_frame(8'h83, 16'h1111, 0);
    n_tests++;
    if (r_dfe !== 0) begin
      n_fail++; $display("FAIL abort_empty got fe=%0d want 0", r_dfe);
    end
  endtask

  task automatic test_out_of_range();
    do_frame(8'hA0, 16'h1234, 24);
    n_tests++;
    if (r_dstb !== 0) begin
      n_fail++; $display("FAIL oor_write got stb=%0d want 0", r_dstb);
    end
    do_frame(8'h20, 16'h0000, 24);
    n_tests++;
    if (rd_cap !== 16'h0000) begin
      n_fail++; $display("FAIL oor_read got %h want 0000", rd_cap);
    end
    do_frame(8'h85, 16'hC3C3, 30);
    n_tests++;
    if (r_dstb !== 1 || last_data !== 16'hC3C3 || r_dfe !== 0) begin
      n_fail++; $display("FAIL extra_sclk got stb=%0d d=%h fe=%0d want 1 c3c3 0", r_dstb, last_data, r_dfe);
    end
  endtask

  task automatic test_random();
    logic [7:0] a8;
    logic [15:0] d;
    for (int n = 0; n < 30; n++) begin
      a8 = {$urandom_range(0, 1) == 1, 7'($urandom_range(0, 19))};
      if ($urandom_range(0, 9) == 0) a8[6:0] = 7'h7F;
      d = 16'($urandom);
      do_frame(a8, d, ($urandom_range(0, 7) == 0) ? $urandom_range(1, 23) : 24);
      n_tests++;
      if (r_dstb !== r_estb || r_dsw !== r_esw || r_dfe !== r_efe) begin
        n_fail++; $display("FAIL rand[%0d] a=%h stb/sw/fe got %0d/%0d/%0d want %0d/%0d/%0d",
                           n, a8, r_dstb, r_dsw, r_dfe, r_estb, r_esw, r_efe);
      end
      if (r_estb == 1) begin
        n_tests++;
        if (last_addr !== a8[6:0] || last_data !== d) begin
          n_fail++; $display("FAIL rand_wr[%0d] got a=%h d=%h want a=%h d=%h", n, last_addr, last_data, a8[6:0], d);
        end
      end
      if (r_is_rd && r_efe == 0 && r_esw == 0) begin
        n_tests++;
        if (rd_cap !== r_erd || oe_err != 0) begin
          n_fail++; $display("FAIL rand_rd[%0d] a=%h got %h oe_err=%0d want %h", n, a8, rd_cap, oe_err, r_erd);
        end
      end
    end
    for (int a = 0; a < NumRegs; a++) begin
      dbg_addr = 7'(a); #1;
      n_tests++;
      if (dbg_data !== m_read(7'(a))) begin
        n_fail++; $display("FAIL rand_dbg[%0d] got %h want %h", a, dbg_data, m_read(7'(a)));
      end
    end
  endtask

  task automatic test_sys_reset();
    int s0, f0;
    do_frame(8'h86, 16'h7777, 24);
    s0 = stb_cnt; f0 = fe_cnt;
    csb_low();
    shift_bits(24'h87_BEEF, 0, 5, 1'b0);
    @(negedge clk) sys_rst_n = 1'b0;
    repeat (3) @(negedge clk);
    sys_rst_n = 1'b1;
    m_reset();
    shift_bits(24'h87_BEEF, 5, 24, 1'b0);
    csb_high();
    n_tests++;
    if (stb_cnt - s0 !== 0 || fe_cnt - f0 !== 0) begin
      n_fail++; $display("FAIL sys_reset_tail got stb=%0d fe=%0d want 0 0", stb_cnt - s0, fe_cnt - f0);
    end
    for (int a = 6; a <= 7; a++) begin
      dbg_addr = 7'(a); #1;
      n_tests++;
      if (dbg_data !== 16'h0000) begin
        n_fail++; $display("FAIL sys_reset_reg[%0d] got %h want 0000", a, dbg_data);
      end
    end
    do_frame(8'h87, 16'h2468, 24);
    n_tests++;
    if (r_dstb !== 1 || last_data !== 16'h2468) begin
      n_fail++; $display("FAIL after_reset_write got stb=%0d d=%h want 1 2468", r_dstb, last_data);
    end
  endtask

  task automatic test_frame_cnt();
    do_frame(8'h84, 16'h0001, 24);
    do_frame(8'h81, 16'h0042, 24);
    do_frame(8'h01, 16'h0000, 24);
    do_frame(8'hFF, 16'h9999, 24);
    do_frame(8'h7F, 16'h0000, 24);
    n_tests++;
    if (rd_cap !== r_erd) begin
      n_fail++; $display("FAIL frame_cnt_read got %h want %h", rd_cap, r_erd);
    end
    n_tests++;
    if (viol_cnt != 0) begin
      n_fail++; $display("FAIL miso_idle got %0d cycles with miso=1 while oe=0 want 0", viol_cnt);
    end
  endtask

  initial begin
    m_reset();
    repeat (4) @(negedge clk);
    sys_rst_n = 1'b1;
    repeat (4) @(negedge clk);
    test_reset();
    test_write_read();
    test_soft_reset();
    test_abort();
    test_out_of_range();
    test_random();
    test_sys_reset();
    test_frame_cnt();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
